// File: rtl/mips_tb_pkg.sv
// Shared types and constants for the instruction ROM responder.
package mips_tb_pkg;

  typedef enum logic [1:0] {
    EMPTY   = 2'd0,
    LOADING = 2'd1,
    LOADED  = 2'd2
  } rom_state_t;

  localparam logic [31:0] RESET_VECTOR = 32'hBFC00000;
  localparam logic [31:0] HALT_ADDR    = 32'h00000000;
  localparam logic [31:0] NOP_WORD     = 32'h00000000;

endpackage

// File: rtl/mips_instr_rom_array.sv
// Program storage: one synchronous write port, one asynchronous read port.
// Contents are never cleared; the top gates reads by the loaded word count.
module mips_instr_rom_array #(
  parameter int DEPTH_WORDS = 256,
  parameter int IDX_W       = $clog2(DEPTH_WORDS)
) (
  input  logic             clk,
  input  logic             we_i,
  input  logic [IDX_W-1:0] waddr_i,
  input  logic [31:0]      wdata_i,
  input  logic [IDX_W-1:0] raddr_i,
  output logic [31:0]      rdata_o
);

  logic [31:0] mem_q [DEPTH_WORDS];

  // Write the accepted load beat into its slot.
  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/mips_instr_rom_responder.sv
// Instruction-port responder: streamed program load, combinational fetch,
// and halt detection (fetch of address 0 once the program is running).
module mips_instr_rom_responder
  import mips_tb_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = RESET_VECTOR,
  parameter int          DEPTH_WORDS = 256,
  localparam int         IDX_W       = $clog2(DEPTH_WORDS)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [31:0]      load_data,
  input  logic             load_last,
  input  logic [31:0]      instr_address,
  output logic [31:0]      instr_readdata,
  output logic             prog_loaded,
  output logic [IDX_W:0]   prog_words,
  output logic             load_error,
  output logic             halted,
  output logic [31:0]      run_cycles
);

  localparam logic [IDX_W:0] LAST_SLOT = (IDX_W+1)'(DEPTH_WORDS - 1);

  rom_state_t     state_q, state_d;
  logic [IDX_W:0] words_q, words_d;
  logic           err_q, err_d;
  logic           halted_q, halted_d;
  logic [31:0]    cyc_q, cyc_d;

  logic        accept;
  logic        running;
  logic [31:0] offset;
  logic [31:0] rdata;
  logic        hit;

  // The word count doubles as the write pointer: slot N is written when N
  // words are already present.
  assign accept  = load_valid && load_ready;
  assign running = (state_q == LOADED) && !halted_q;

  mips_instr_rom_array #(
    .DEPTH_WORDS(DEPTH_WORDS),
    .IDX_W      (IDX_W)
  ) u_array (
    .clk    (clk),
    .we_i   (accept),
    .waddr_i(words_q[IDX_W-1:0]),
    .wdata_i(load_data),
    .raddr_i(offset[IDX_W+1:2]),
    .rdata_o(rdata)
  );

  // Next-state logic for the load FSM, word count, error and halt tracking.
  always_comb begin
    state_d  = state_q;
    words_d  = words_q;
    err_d    = err_q;
    halted_d = halted_q;
    cyc_d    = cyc_q;
    case (state_q)
      EMPTY, LOADING: begin
        if (accept) begin
          words_d = words_q + 1'b1;
          if (load_last) begin
            state_d = LOADED;
          end else if (words_q == LAST_SLOT) begin
            state_d = LOADED;
            err_d   = 1'b1;
          end else begin
            state_d = LOADING;
          end
        end
      end
      LOADED: begin
        if (running) begin
          if (cyc_q != 32'hFFFFFFFF) cyc_d = cyc_q + 32'd1;
          if (instr_address == HALT_ADDR) halted_d = 1'b1;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  // State registers; reset discards all load progress.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= EMPTY;
      words_q  <= '0;
      err_q    <= 1'b0;
      halted_q <= 1'b0;
      cyc_q    <= '0;
    end else begin
      state_q  <= state_d;
      words_q  <= words_d;
      err_q    <= err_d;
      halted_q <= halted_d;
      cyc_q    <= cyc_d;
    end
  end

  // Fetch decode: the base compare stops addresses below BASE_ADDR from
  // wrapping into range through the subtraction.
  always_comb begin
    offset = instr_address - BASE_ADDR;
    hit    = (state_q == LOADED) &&
             (instr_address[1:0] == 2'b00) &&
             (instr_address >= BASE_ADDR) &&
             ((offset >> 2) < 32'(words_q));
    instr_readdata = hit ? rdata : NOP_WORD;
  end

  assign load_ready  = (state_q != LOADED);
  assign prog_loaded = (state_q == LOADED);
  assign prog_words  = words_q;
  assign load_error  = err_q;
  assign halted      = halted_q;
  assign run_cycles  = cyc_q;

endmodule
